// File: rtl/bf_phase_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bf_phase_sequencer
// Iteration controller for the Bellman-Ford column-memory address generator.
// It runs the initialisation write sweep, produces the phase-counter
// read/write advance pulses for each relaxation sweep, and counts iterations
// until convergence or the iteration limit is reached.
//
// Ports:
//   clk                         clock
//   rst_global_n                asynchronous active-low reset
//   start                       run request, honoured only in IDLE or DONE
//   abort                       synchronous return to IDLE from any state
//   iteration_done              AGU flag: write address == last column
//   update_flag                 datapath: a distance improved this cycle
//   agu_rst                     one-cycle pulse resetting the AGU
//   write_enable_cu             AGU write advance during the init sweep
//   init_write                  datapath writes the initial distance value
//   pre_rollover_phase_counter  read-advance pulse (phase == last-1)
//   rollover_phase_counter      write-advance pulse (phase == last)
//   busy                        high outside IDLE/DONE
//   done                        high in DONE
//   converged                   valid with done: last sweep had no update
//   sync_error                  sticky AGU/column-count mismatch
//   iteration_count             completed iterations
// ---------------------------------------------------------------------------
module bf_phase_sequencer #(
  parameter int number_of_columns = 768,
  parameter int phase_length      = 4,
  parameter int max_iterations    = 31,
  parameter int iter_w            = 6
) (
  input  logic              clk,
  input  logic              rst_global_n,
  input  logic              start,
  input  logic              abort,
  input  logic              iteration_done,
  input  logic              update_flag,
  output logic              agu_rst,
  output logic              write_enable_cu,
  output logic              init_write,
  output logic              pre_rollover_phase_counter,
  output logic              rollover_phase_counter,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              sync_error,
  output logic [iter_w-1:0] iteration_count
);

  localparam int phase_w = (phase_length > 1) ? $clog2(phase_length) : 1;
  localparam int col_w   = (number_of_columns > 1) ? $clog2(number_of_columns) : 1;

  localparam logic [phase_w-1:0] phase_last = phase_w'(phase_length - 1);
  localparam logic [phase_w-1:0] phase_pre  = phase_w'(phase_length - 2);
  localparam logic [col_w-1:0]   col_last   = col_w'(number_of_columns - 1);
  localparam logic [iter_w-1:0]  iter_limit = iter_w'(max_iterations);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AGU_RST = 3'd1,
    INIT    = 3'd2,
    RUN     = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [phase_w-1:0] phase;
  logic [phase_w-1:0] phase_next;
  logic [col_w-1:0]   col;
  logic [col_w-1:0]   col_next;
  logic               any_update;
  logic               any_update_next;
  logic [iter_w-1:0]  count_next;
  logic               converged_next;
  logic               sync_error_next;

  // Phase pulses decode the registered phase so they align with the AGU edge.
  assign pre_rollover_phase_counter = (state == RUN) && (phase == phase_pre);
  assign rollover_phase_counter     = (state == RUN) && (phase == phase_last);

  // Next-state and next-value logic for the sequencer.
  always_comb begin
    state_next      = state;
    phase_next      = phase;
    col_next        = col;
    any_update_next = any_update;
    count_next      = iteration_count;
    converged_next  = converged;
    sync_error_next = sync_error;
    if (abort) begin
      // abort wins over start and over any end-of-sweep decision;
      // iteration_count and sync_error keep their values.
      state_next      = IDLE;
      phase_next      = phase_w'(0);
      col_next        = col_w'(0);
      any_update_next = 1'b0;
      converged_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = AGU_RST;
          end else begin
            state_next = IDLE;
          end
        end
        AGU_RST: begin
          state_next      = INIT;
          count_next      = iter_w'(0);
          converged_next  = 1'b0;
          sync_error_next = 1'b0;
          any_update_next = 1'b0;
          phase_next      = phase_w'(0);
          col_next        = col_w'(0);
        end
        INIT: begin
          // Sweep ends on the write to the last column; the AGU wraps itself.
          if (iteration_done && write_enable_cu) begin
            state_next = RUN;
            phase_next = phase_w'(0);
            col_next   = col_w'(0);
          end else begin
            state_next = INIT;
          end
        end
        RUN: begin
          any_update_next = any_update | update_flag;
          if (rollover_phase_counter) begin
            phase_next = phase_w'(0);
            if (col == col_last) begin
              state_next = CHECK;
              // AGU must agree that this was the last column.
              if (!iteration_done) begin
                sync_error_next = 1'b1;
              end else begin
                sync_error_next = sync_error;
              end
            end else begin
              col_next = col + col_w'(1);
              // AGU reporting the last column before we reach it.
              if (iteration_done) begin
                sync_error_next = 1'b1;
              end else begin
                sync_error_next = sync_error;
              end
            end
          end else begin
            phase_next = phase + phase_w'(1);
          end
        end
        CHECK: begin
          count_next = iteration_count + iter_w'(1);
          if (!any_update) begin
            state_next     = DONE;
            converged_next = 1'b1;
          end else if (count_next == iter_limit) begin
            state_next     = DONE;
            converged_next = 1'b0;
          end else begin
            state_next      = RUN;
            any_update_next = 1'b0;
            col_next        = col_w'(0);
            phase_next      = phase_w'(0);
          end
        end
        DONE: begin
          if (start) begin
            state_next = AGU_RST;
          end else begin
            state_next = DONE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_global_n) begin
    if (!rst_global_n) begin
      state           <= IDLE;
      phase           <= phase_w'(0);
      col             <= col_w'(0);
      any_update      <= 1'b0;
      iteration_count <= iter_w'(0);
      converged       <= 1'b0;
      sync_error      <= 1'b0;
      agu_rst         <= 1'b0;
      write_enable_cu <= 1'b0;
      init_write      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_next;
      phase           <= phase_next;
      col             <= col_next;
      any_update      <= any_update_next;
      iteration_count <= count_next;
      converged       <= converged_next;
      sync_error      <= sync_error_next;
      // abort also resets the AGU in the cycle it lands in IDLE.
      agu_rst         <= abort | (state_next == AGU_RST);
      write_enable_cu <= (state_next == INIT);
      init_write      <= (state_next == INIT);
      busy            <= (state_next != IDLE) && (state_next != DONE);
      done            <= (state_next == DONE);
    end
  end

endmodule

// File: doc/bf_phase_sequencer.md
Name: bf_phase_sequencer

Overview:
- Iteration controller that drives the address generator of the Bellman-Ford column memories.
- Produces the phase-counter pre-rollover/rollover pulses that advance AGU read/write addresses, runs the initialisation write sweep, and counts relaxation iterations.
- Consumes the AGU iteration_done flag and stops on convergence or at the iteration limit.
- Sits between the top-level start/abort control and the AGU/datapath.

Parameters:
- number_of_columns, 768, columns per iteration sweep; must match the AGU.
- phase_length, 4, cycles per column phase, >=2.
- max_iterations, 31, iteration limit (nodes-1).
- iter_w, 6, iteration_count width.

Ports:
- clk  in  1  clock.
- rst_global_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse, honoured only in IDLE or DONE.
- abort  in  1  synchronous; forces IDLE from any state.
- iteration_done  in  1  from AGU: write address == number_of_columns-1.
- update_flag  in  1  datapath: a distance improved this cycle.
- agu_rst  out  1  one-cycle active-high pulse to AGU rst_global.
- write_enable_cu  out  1  AGU write advance during init sweep.
- init_write  out  1  datapath writes INF/source init value.
- pre_rollover_phase_counter  out  1  read-advance pulse.
- rollover_phase_counter  out  1  write-advance pulse.
- busy  out  1  high outside IDLE/DONE.
- done  out  1  high in DONE.
- converged  out  1  valid with done; 1 = no update in last iteration.
- sync_error  out  1  sticky AGU/column-count mismatch.
- iteration_count  out  iter_w  completed iterations.

Behaviour:
- Reset (async, rst_global_n=0): state IDLE; all outputs 0; phase, column and iteration counters 0; any_update 0.
- All state updates are on the rising edge of clk. All outputs are registered except pre_rollover/rollover, which decode the registered phase counter and state.
- IDLE: start -> AGU_RST.
- AGU_RST: one cycle, agu_rst=1. Clear iteration_count, sync_error and converged. Next state INIT.
- INIT:
  - write_enable_cu=1 and init_write=1 every cycle.
  - The sweep ends in the cycle where iteration_done=1 and write_enable_cu=1; the AGU self-wraps to 0.
  - Next state RUN with phase=0 and column counter=0.
  - First write_enable_cu occurs 2 cycles after the start sample.
- RUN:
  - Phase counter counts 0..phase_length-1 and wraps.
  - pre_rollover_phase_counter=1 when phase==phase_length-2.
  - rollover_phase_counter=1 when phase==phase_length-1.
  - The column counter increments on each rollover.
  - any_update |= update_flag in every RUN cycle, including the final rollover cycle.
  - End of iteration is the rollover cycle with column counter==number_of_columns-1.
  - If iteration_done != 1 in that cycle, set sync_error. Also set sync_error if iteration_done=1 on any earlier rollover in the sweep.
  - Next state CHECK.
- CHECK (1 cycle, no phase pulses):
  - iteration_count++.
  - If any_update==0: go to DONE with converged=1.
  - Else, if the incremented count==max_iterations: go to DONE with converged=0.
  - Otherwise clear any_update and the column counter, set phase=0, and return to RUN.
  - No agu_rst is issued; AGU addresses have self-wrapped.
- DONE: done=1, busy=0; iteration_count and converged hold. start -> AGU_RST (new run).
- abort in any state:
  - Next state IDLE.
  - agu_rst=1 for that following cycle.
  - done, converged and busy cleared; iteration_count holds its value.
  - abort has priority over start and over any end-of-iteration decision.
- start while busy is ignored.
- The phase counter is width clog2(phase_length). The column counter is clog2(number_of_columns) bits and never exceeds number_of_columns-1.
- Async reset mid-run returns to the reset state immediately. No pulse is emitted on release.

Test Plan (number_of_columns=4, phase_length=4, max_iterations=3, behavioural AGU model attached):
- Reset then start at cycle 0 -> agu_rst at cycle 1, write_enable_cu/init_write high cycles 2-5, RUN from cycle 6; pre_rollover at cycles 8, 12, 16, 20; rollover at 9, 13, 17, 21; CHECK at 22.
- update_flag never asserted -> DONE after first iteration, iteration_count=1, converged=1, sync_error=0.
- update_flag pulsed once per iteration (including on the final rollover cycle) -> DONE after 3 iterations, iteration_count=3, converged=0.
- AGU model forced to raise iteration_done one rollover early -> sync_error=1 and remains 1 through DONE.
- abort asserted mid-RUN on a rollover cycle -> next cycle IDLE with agu_rst=1, no further phase pulses, busy=0, done=0.
- start pulsed during RUN is ignored. rst_global_n low mid-INIT -> all outputs 0 asynchronously; new start after release repeats the cycle-0 sequence exactly.
